// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
//   state_e          : transfer state machine encoding
//   Default*Base     : default byte base addresses of the two regions
//   LfsrSeed/LfsrTaps: wait-state LFSR reset value and Galois tap mask
//   lfsr_next()      : one step of the 16-bit Galois LFSR (taps 16,14,13,11)
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess
    } state_e;

    localparam logic [31:0] DefaultInstrBase = 32'hBFC00000;
    localparam logic [31:0] DefaultDataBase  = 32'h00000000;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    // Right-shifting Galois form: taps 16,14,13,11 map to mask bits 15,13,12,10.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/avalon_wait_gen.sv
// Wait-state generator for avalon_mem_responder.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   start      : request accepted this cycle (IDLE with a single read or write)
//   busy       : responder is in its WAIT state
//   wait_cnt   : waitrequest-high cycles for a request starting this cycle
//   done       : last WAIT-state cycle; ACCESS follows
// Build option: AVALON_MEM_RANDOM_WAIT_EN draws each transfer's wait count from a
// 16-bit Galois LFSR as lfsr[3:0] mod (WAIT_CYCLES+1); otherwise it is fixed.
module avalon_wait_gen
    import avalon_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       busy,
    output logic [3:0] wait_cnt,
    output logic       done
);

`ifdef AVALON_MEM_RANDOM_WAIT_EN
    logic [15:0] lfsr_q;

    // One step per accepted request, including zero-wait ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LfsrSeed;
        end else if (start) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign wait_cnt = 4'({1'b0, lfsr_q[3:0]} % 5'(WAIT_CYCLES + 1));
`else
    assign wait_cnt = 4'(WAIT_CYCLES);
`endif

    // The IDLE request cycle already shows waitrequest high, so the counter holds
    // the number of WAIT-state cycles still to come (wait_cnt - 1).
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else if (start) begin
            cnt_q <= (wait_cnt == 4'd0) ? 4'd0 : wait_cnt - 4'd1;
        end else if (busy && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end else if (!busy) begin
            cnt_q <= 4'd0;
        end
    end

    assign done = busy && (cnt_q == 4'd1);

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory with an instruction region at the reset vector and a data
// region, both word-addressed, with programmable wait states per transfer.
// Ports:
//   clk         : clock, all state on the rising edge
//   reset       : asynchronous active-low reset (memory contents are kept)
//   address     : byte address from the master
//   read, write : request strobes; both high is an erroneous no-op
//   byteenable  : write byte lanes, bit n covers bits 8n+7:8n
//   writedata   : write data
//   readdata    : read data, valid while read=1 and waitrequest=0, else 0
//   waitrequest : stall, master holds its inputs while high
//   bus_error   : sticky error flag, cleared only by reset
// Build option: AVALON_MEM_RANDOM_WAIT_EN selects LFSR-randomised wait counts.
module avalon_mem_responder
    import avalon_mem_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE  = DefaultInstrBase,
    parameter int unsigned INSTR_WORDS = 1024,
    parameter logic [31:0] DATA_BASE   = DefaultDataBase,
    parameter int unsigned DATA_WORDS  = 4096,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        bus_error
);

    localparam int unsigned IAW = $clog2(INSTR_WORDS);
    localparam int unsigned DAW = $clog2(DATA_WORDS);

    logic [31:0] instr_mem [INSTR_WORDS];
    logic [31:0] data_mem  [DATA_WORDS];

    // Both regions start zeroed.
    initial begin
        for (int i = 0; i < int'(INSTR_WORDS); i++) instr_mem[i] = 32'h0;
        for (int i = 0; i < int'(DATA_WORDS); i++) data_mem[i] = 32'h0;
    end

    state_e state_q;
    logic   bus_error_q;

    // Request decode
    logic rd_only, wr_only, req, both;

    assign rd_only = read & ~write;
    assign wr_only = write & ~read;
    assign req     = rd_only | wr_only;
    assign both    = read & write;

    // Address decode; the subtraction wraps so a single compare gives the range check.
    logic [31:0]    instr_off, data_off;
    logic           instr_hit, data_hit, aligned, addr_ok;
    logic [IAW-1:0] instr_idx;
    logic [DAW-1:0] data_idx;

    assign instr_off = address - INSTR_BASE;
    assign data_off  = address - DATA_BASE;
    assign instr_idx = instr_off[IAW+1:2];
    assign data_idx  = data_off[DAW+1:2];
    assign instr_hit = (instr_off >> 2) < 32'(INSTR_WORDS);
    assign data_hit  = (data_off >> 2) < 32'(DATA_WORDS);
    assign aligned   = (address[1:0] == 2'b00);
    assign addr_ok   = aligned && (instr_hit || data_hit);

    // Wait-state generation
    logic       start, in_wait, wait_done;
    logic [3:0] wait_cnt;

    assign start   = (state_q == StIdle) && req;
    assign in_wait = (state_q == StWait);

    avalon_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (in_wait),
        .wait_cnt (wait_cnt),
        .done     (wait_done)
    );

    // The access cycle is either the ACCESS state or a zero-wait request seen in IDLE.
    logic access;

    assign access = (state_q == StAccess) || (start && (wait_cnt == 4'd0));

    // Outputs are forced quiet while reset is asserted, even if the master still drives.
    assign waitrequest = reset && (in_wait || (start && (wait_cnt != 4'd0)));
    assign bus_error   = bus_error_q;

    logic [31:0] rd_word;

    assign rd_word  = instr_hit ? instr_mem[instr_idx] : data_mem[data_idx];
    assign readdata = (reset && access && rd_only && addr_ok) ? rd_word : 32'h0;

    // Instruction region wins where the two regions overlap.
    logic wr_ok, instr_we, data_we, err_set;

    assign wr_ok    = reset && access && wr_only && addr_ok;
    assign instr_we = wr_ok && instr_hit;
    assign data_we  = wr_ok && !instr_hit && data_hit;

    // Both strobes high is never a request, so it also covers a mid-WAIT change to both.
    assign err_set = both
                   || (access && req && !addr_ok)
                   || (in_wait && !req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bus_error_q <= 1'b0;
        end else begin
            if (err_set) begin
                bus_error_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start && wait_cnt != 4'd0) begin
                        state_q <= (wait_cnt == 4'd1) ? StAccess : StWait;
                    end
                end
                StWait: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end else if (wait_done) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (instr_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) instr_mem[instr_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) data_mem[data_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
module tb_avalon_mem_responder;

    localparam logic [31:0] IBASE  = 32'hBFC00000;
    localparam logic [31:0] DBASE  = 32'h00000000;
    localparam int unsigned IWORDS = 256;
    localparam int unsigned DWORDS = 512;
    localparam int unsigned WAITS  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        bus_error;

    logic [31:0] address0 = 32'h0;
    logic        read0 = 1'b0;
    logic        write0 = 1'b0;
    logic [3:0]  byteenable0 = 4'h0;
    logic [31:0] writedata0 = 32'h0;
    logic [31:0] readdata0;
    logic        waitrequest0;
    logic        bus_error0;

    always #5 clk = ~clk;

    avalon_mem_responder #(
        .INSTR_BASE  (IBASE),
        .INSTR_WORDS (IWORDS),
        .DATA_BASE   (DBASE),
        .DATA_WORDS  (DWORDS),
        .WAIT_CYCLES (WAITS),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .bus_error   (bus_error)
    );

    avalon_mem_responder #(
        .INSTR_BASE  (IBASE),
        .INSTR_WORDS (IWORDS),
        .DATA_BASE   (DBASE),
        .DATA_WORDS  (DWORDS),
        .WAIT_CYCLES (0),
        .INIT_FILE   ("")
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .address     (address0),
        .read        (read0),
        .write       (write0),
        .byteenable  (byteenable0),
        .writedata   (writedata0),
        .readdata    (readdata0),
        .waitrequest (waitrequest0),
        .bus_error   (bus_error0)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sparse word store keyed by byte address, plus sticky error flag.
    logic [31:0] model [logic [31:0]];
    bit          model_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit mapped(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (a[1:0] == 2'b00) &&
               ((x >= 64'(IBASE) && x < 64'(IBASE) + 64'(4 * IWORDS)) ||
                (x >= 64'(DBASE) && x < 64'(DBASE) + 64'(4 * DWORDS)));
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (mapped(a) && model.exists(a)) return model[a];
        return 32'h0;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w;
        if (!mapped(a)) return;
        w = mread(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        model[a] = w;
    endtask

    function automatic logic [31:0] pick_valid();
        int unsigned slot;
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 0) ? IBASE : DBASE;
        slot = $urandom_range(0, 7);
        if (slot == 7) slot = ((base == IBASE) ? IWORDS : DWORDS) - 1;
        return base + 32'(slot * 4);
    endfunction

    // One transfer on dut; called just after a rising edge.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input string tag, output logic [31:0] rdata);
        int          waits;
        int          exp_waits;
        logic [31:0] exp_rd;
        bit          err_before;
        err_before = model_err;
        exp_waits  = (rd ^ wr) ? int'(WAITS) : 0;
        exp_rd     = (rd && !wr) ? mread(a) : 32'h0;
        read = rd; write = wr; address = a; byteenable = be; writedata = wd;
        waits = 0;
        @(negedge clk);
        while (waitrequest === 1'b1 && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        rdata = readdata;
        chk({tag, " waits"}, 32'(waits), 32'(exp_waits));
        if (rd) chk({tag, " readdata"}, readdata, exp_rd);
        chk({tag, " bus_error before edge"}, 32'(bus_error), 32'(err_before));
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        if (wr && !rd) mwrite(a, be, wd);
        if ((rd && wr) || ((rd ^ wr) && !mapped(a))) model_err = 1'b1;
        chk({tag, " bus_error"}, 32'(bus_error), 32'(model_err));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        chk("reset waitrequest", 32'(waitrequest), 32'd0);
        chk("reset bus_error", 32'(bus_error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_err = 1'b0;
    endtask

    logic [31:0] rdata;
    logic [31:0] a;
    int unsigned op;

    initial begin
        #12;
        read = 1'b1;
        #1;
        chk("in reset waitrequest", 32'(waitrequest), 32'd0);
        chk("in reset readdata", readdata, 32'h0);
        chk("in reset bus_error", 32'(bus_error), 32'd0);
        read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Boot word at the reset vector
        xfer(1'b0, 1'b1, IBASE, 4'hF, 32'h3C021234, "boot write", rdata);
        xfer(1'b1, 1'b0, IBASE, 4'h0, 32'h0, "boot read", rdata);
        chk("boot word", rdata, 32'h3C021234);

        // Byte-lane merge
        xfer(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "word write", rdata);
        xfer(1'b0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, "lane0 write", rdata);
        xfer(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "merge read", rdata);
        chk("merged word", rdata, 32'hDEADBEAA);
        xfer(1'b0, 1'b1, 32'h10, 4'h0, 32'h12345678, "be0 write", rdata);
        xfer(1'b1, 1'b0, 32'h10, 4'h5, 32'h0, "be0 read", rdata);

        // Region boundaries (last word of each region)
        xfer(1'b0, 1'b1, IBASE + 32'(4 * (IWORDS - 1)), 4'hF, 32'hA5A5_0001, "ilast w", rdata);
        xfer(1'b0, 1'b1, DBASE + 32'(4 * (DWORDS - 1)), 4'hF, 32'h5A5A_0002, "dlast w", rdata);
        xfer(1'b1, 1'b0, IBASE + 32'(4 * (IWORDS - 1)), 4'h0, 32'h0, "ilast r", rdata);
        xfer(1'b1, 1'b0, DBASE + 32'(4 * (DWORDS - 1)), 4'h0, 32'h0, "dlast r", rdata);

        // Random legal traffic against the model
        for (int i = 0; i < 40; i++) begin
            a  = pick_valid();
            op = $urandom_range(0, 1);
            xfer(op == 0, op == 1, a, 4'($urandom), $urandom, "rand", rdata);
        end

        // Zero-wait instance: back-to-back transfers never stall
        write0 = 1'b1; byteenable0 = 4'hF; address0 = 32'h0; writedata0 = 32'hCAFE0001;
        @(negedge clk);
        chk("zw write0 waitrequest", 32'(waitrequest0), 32'd0);
        @(posedge clk); #1;
        address0 = 32'h4; writedata0 = 32'hCAFE0002;
        @(negedge clk);
        chk("zw write4 waitrequest", 32'(waitrequest0), 32'd0);
        @(posedge clk); #1;
        write0 = 1'b0; read0 = 1'b1; address0 = 32'h0;
        @(negedge clk);
        chk("zw read0 waitrequest", 32'(waitrequest0), 32'd0);
        chk("zw read0 readdata", readdata0, 32'hCAFE0001);
        @(posedge clk); #1;
        address0 = 32'h4;
        @(negedge clk);
        chk("zw read4 waitrequest", 32'(waitrequest0), 32'd0);
        chk("zw read4 readdata", readdata0, 32'hCAFE0002);
        @(posedge clk); #1;
        read0 = 1'b0;
        chk("zw bus_error", 32'(bus_error0), 32'd0);

        // Error cases, each from a fresh reset (memory must survive reset)
        xfer(1'b1, 1'b0, 32'h00100000, 4'h0, 32'h0, "unmapped read", rdata);
        pulse_reset();
        xfer(1'b1, 1'b0, IBASE, 4'h0, 32'h0, "post-reset boot read", rdata);
        xfer(1'b0, 1'b1, 32'h8, 4'hF, 32'h0BAD_0008, "pre both write", rdata);
        xfer(1'b1, 1'b1, 32'h8, 4'hF, 32'hFFFF_FFFF, "both", rdata);
        pulse_reset();
        xfer(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, "after both read", rdata);
        xfer(1'b1, 1'b0, 32'h2, 4'h0, 32'h0, "misaligned read", rdata);
        pulse_reset();
        xfer(1'b0, 1'b1, 32'h12, 4'hF, 32'h1111_1111, "misaligned write", rdata);
        pulse_reset();
        xfer(1'b0, 1'b1, IBASE + 32'(4 * IWORDS), 4'hF, 32'h2222_2222, "past ilast w", rdata);
        pulse_reset();
        xfer(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "after bad writes read", rdata);

        for (int i = 0; i < 8; i++) begin
            pulse_reset();
            op = $urandom_range(0, 2);
            if (op == 0) a = 32'h00100000 + 32'($urandom_range(0, 7) * 4);
            else if (op == 1) a = pick_valid() + 32'($urandom_range(1, 3));
            else a = pick_valid();
            if (op == 2) xfer(1'b1, 1'b1, a, 4'hF, $urandom, "rand both", rdata);
            else xfer($urandom_range(0, 1) == 1, 1'b0, a, 4'hF, 32'h0, "rand bad", rdata);
            if (op != 2) xfer(1'b0, 1'b1, a, 4'hF, $urandom, "rand bad w", rdata);
        end

        // Master drops its request mid-WAIT
        pulse_reset();
        read = 1'b1; address = 32'h10;
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        model_err = 1'b1;
        chk("drop bus_error", 32'(bus_error), 32'd1);
        chk("drop waitrequest", 32'(waitrequest), 32'd0);
        xfer(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "after drop read", rdata);

        // Reset during WAIT discards the pending write
        pulse_reset();
        xfer(1'b0, 1'b1, 32'h20, 4'hF, 32'h1111_2222, "old write", rdata);
        write = 1'b1; address = 32'h20; byteenable = 4'hF; writedata = 32'h9999_8888;
        @(negedge clk);
        chk("abort waitrequest high", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort waitrequest in reset", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        reset = 1'b1;
        model_err = 1'b0;
        xfer(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "abort read", rdata);
        chk("abort old value", rdata, 32'h1111_2222);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
